// File: rtl/clz_seq_pkg.sv
// Shared encodings and default sizes for the sequential leading-zero/one counter.
package clz_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_CLZ = 1'b0;
    localparam logic OP_CLO = 1'b1;

    localparam int W_DEF  = 32;
    localparam int CH_DEF = 8;

endpackage

// File: rtl/clz_seq_chunk.sv
// Combinational leading-zero count of one CH-bit chunk; all-zero input gives CH.
module clz_chunk #(
    parameter int CH   = 8,              // chunk width
    parameter int LZ_W = $clog2(CH) + 1  // width of the count, holds 0..CH
) (
    input  logic [CH-1:0]   i_chunk,
    output logic [LZ_W-1:0] o_lz
);

    // Scanning upward lets the highest set bit be the last (winning) assignment.
    always_comb begin
        o_lz = LZ_W'(CH);
        for (int i = 0; i < CH; i++) begin
            if (i_chunk[i]) begin
                o_lz = LZ_W'(CH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/clz_seq.sv
// Multi-cycle CLZ/CLO: scans the operand one CH-bit chunk per cycle from the MSB end.
module clz_seq
    import clz_seq_pkg::*;
#(
    parameter int W  = W_DEF,  // operand width
    parameter int CH = CH_DEF  // chunk width scanned per cycle, divides W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] r
);

    localparam int NCH   = W / CH;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = $clog2(W) + 1;
    localparam int LZ_W  = $clog2(CH) + 1;

    state_t           r_state;
    state_t           w_next;
    logic [W-1:0]     r_sh;
    logic [W-1:0]     w_sh_in;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_sum;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_res;
    logic [LZ_W-1:0]  w_lz;
    logic             w_top_nz;
    logic             w_last;
    logic             w_load;
    logic             w_step;
    logic             w_fin;

    clz_chunk #(
        .CH   (CH),
        .LZ_W (LZ_W)
    ) u_chunk (
        .i_chunk (r_sh[W-1 -: CH]),
        .o_lz    (w_lz)
    );

    assign w_top_nz = |r_sh[W-1 -: CH];
    assign w_last   = (r_idx == IDX_W'(NCH - 1));
    assign w_sum    = r_cnt + CNT_W'(w_lz);

    // CLO is handled by inverting once at load time and then counting zeros.
    always_comb begin
        w_sh_in = a;
        case (op)
            OP_CLZ:  w_sh_in = a;
            OP_CLO:  w_sh_in = ~a;
            default: w_sh_in = a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fin  = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (flush) begin
                    w_next = IDLE;
                end else if (start) begin
                    w_load = 1'b1;
                    w_next = SCAN;
                end else begin
                    w_next = IDLE;
                end
            end
            SCAN: begin
                if (flush) begin
                    w_next = IDLE;
                end else if (w_top_nz || w_last) begin
                    w_fin  = 1'b1;
                    w_next = DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
            r_idx <= '0;
            r_res <= '0;
        end else begin
            if (w_load) begin
                r_sh  <= w_sh_in;
                r_cnt <= '0;
                r_idx <= '0;
            end else if (w_step) begin
                r_sh  <= r_sh << CH;
                r_cnt <= r_cnt + CNT_W'(CH);
                r_idx <= r_idx + 1'b1;
            end
            // An all-zero final chunk means the whole operand was zero.
            if (w_fin) begin
                r_res <= w_top_nz ? W'(w_sum) : W'(W);
            end
        end
    end

    assign busy = (r_state == SCAN);
    assign done = (r_state == DONE);
    assign r    = r_res;

endmodule

// File: tb/tb_clz_seq.sv
// Self-checking bench for clz_seq: latency-countdown reference model plus directed cases.
module tb_clz_seq;

    localparam int W   = 32;
    localparam int CH  = 8;
    localparam int NCH = W / CH;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] r;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    clz_seq #(.W(W), .CH(CH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .r     (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int ref_clz(input logic [W-1:0] v);
        int n = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) break;
            n++;
        end
        return n;
    endfunction

    // Reference: an accepted request finishes after a fixed number of scan cycles,
    // k+1 where k is the index of the first nonzero chunk (capped at the last chunk).
    int           m_scan_left;
    logic         m_done;
    logic [W-1:0] m_r;
    logic [W-1:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_scan_left = 0;
            m_done      = 1'b0;
            m_r         = '0;
            m_pend      = '0;
        end else if (flush) begin
            m_scan_left = 0;
            m_done      = 1'b0;
        end else if (m_scan_left > 0) begin
            m_scan_left = m_scan_left - 1;
            m_done      = (m_scan_left == 0);
            if (m_scan_left == 0) m_r = m_pend;
        end else begin
            m_done = 1'b0;
            if (start) begin
                int n;
                int k;
                n = ref_clz(op ? ~a : a);
                k = n / CH;
                if (k > NCH - 1) k = NCH - 1;
                m_pend      = W'(n);
                m_scan_left = k + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", W'(busy), W'(m_scan_left > 0));
        check("done", W'(done), W'(m_done));
        check("r",    r,        m_r);
    end

    task automatic wait_done(output int lat, output logic got, input int t0);
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                lat = cyc - t0;
            end
        end
    endtask

    task automatic run_op(input string name, input logic o, input logic [W-1:0] av,
                          input int exp_r, input int exp_lat);
        int   t0;
        int   lat;
        logic got;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = av; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, got, t0);
        check({name, "_seen"}, W'(got), W'(1));
        check({name, "_lat"},  W'(lat), W'(exp_lat));
        check({name, "_r"},    r,       W'(exp_r));
    endtask

    initial begin
        int   t0;
        int   d;
        int   lat;
        int   seen;
        logic got;

        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; flush = 1'b0;
        #23;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_r",    r,        W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("msb",      1'b0, 32'h8000_0000, 0,  2);
        run_op("lsb",      1'b0, 32'h0000_0001, 31, 5);
        run_op("zero",     1'b0, 32'h0000_0000, 32, 5);
        run_op("clo16",    1'b1, 32'hFFFF_0F00, 16, 4);
        run_op("clo_ones", 1'b1, 32'hFFFF_FFFF, 32, 5);
        run_op("lsb2",     1'b0, 32'h0000_0001, 31, 5);

        // Start while busy is ignored; a start during the done cycle chains.
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; a = 32'h0000_0001; t0 = cyc;
        @(posedge clk); #1;
        a = 32'hFFFF_FFFF; op = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, got, t0);
        check("b2b_first_seen", W'(got), W'(1));
        check("b2b_first_lat",  W'(lat), W'(5));
        check("b2b_first_r",    r,       W'(31));
        start = 1'b1; op = 1'b0; a = 32'h00F0_0000; d = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, got, d);
        check("b2b_second_seen", W'(got), W'(1));
        check("b2b_second_lat",  W'(lat), W'(3));
        check("b2b_second_r",    r,       W'(8));

        // Flush in the second scan cycle.
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; a = 32'h0000_0000;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", W'(busy), W'(0));
        check("flush_r",    r,        W'(8));
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("flush_no_done", W'(seen), W'(0));

        // Reset in the middle of a scan.
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; a = 32'h0000_0000;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_done", W'(done), W'(0));
        check("mid_rst_r",    r,        W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("after_rst", 1'b1, 32'hFFFF_0F00, 16, 4);

        // Random traffic, checked every cycle by the reference model.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            op    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = '0;
                1:       a = '1;
                default: a = $urandom >> $urandom_range(0, 31);
            endcase
            flush = ($urandom_range(0, 19) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        repeat (8) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/clz_seq.md
CLZ_SEQ -- requirements
Module: clz_seq

Interface
REQ-001: Parameters SHALL be declared one per line: name, default, meaning.
REQ-002: Parameter W, default 32, is the operand width.
REQ-003: Parameter CH, default 8, is the chunk width scanned per cycle; W SHALL be a multiple of CH.
REQ-004: Ports SHALL be declared one per line: name, direction, width, meaning, with clock and reset first.
REQ-005: Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-006: Port rst_n, input, 1, is the reset; reset SHALL be asynchronous and active-low.
REQ-007: Port start, input, 1, is a request pulse; it SHALL be sampled only when busy is 0.
REQ-008: Port op, input, 1, selects the operation: 0 = CLZ, 1 = CLO; it SHALL be sampled together with start.
REQ-009: Port a, input, W, is the operand from rs; it SHALL be sampled together with start.
REQ-010: Port flush, input, 1, is a synchronous abort, e.g. on a pipeline or exception flush.
REQ-011: Port busy, output, 1, SHALL be 1 while an operation is in progress.
REQ-012: Port done, output, 1, is a one-cycle pulse marking r valid for the new result.
REQ-013: Port r, output, W, is the leading-zero or leading-one count, range 0..W.

Function
REQ-014: The FSM SHALL have three states: IDLE, SCAN, DONE.
REQ-015: In IDLE, or in DONE, with start=1 and flush=0, the block SHALL latch sh = (op ? ~a : a), set cnt=0 and idx=0, and go to SCAN.
REQ-016: In SCAN, the top chunk sh[W-1:W-CH] SHALL be examined with the leading-zero count lz (0..CH) from sub-module clz_chunk.
REQ-017: In SCAN with a nonzero top chunk, the block SHALL set r <= cnt+lz and go to DONE.
REQ-018: In SCAN with a zero top chunk and idx < W/CH-1, the block SHALL set cnt += CH, shift sh left by CH, increment idx, and stay in SCAN.
REQ-019: In SCAN with a zero top chunk and idx = W/CH-1, the block SHALL set r <= W and go to DONE.
REQ-020: In DONE, done SHALL be 1 for exactly one cycle; the next state SHALL be SCAN if start=1 (back-to-back), otherwise IDLE.
REQ-021: busy SHALL be 1 in SCAN only; start while busy=1 SHALL be ignored with no queuing.
REQ-022: Latency: with the start edge at T and the first nonzero chunk at index k (0-based, or W/CH-1 if none), done SHALL be high in cycle T+k+2.
REQ-023: Latency SHALL be 2..5 cycles for the default parameters.
REQ-024: r SHALL hold its last value until the next completion and SHALL NOT change on start or flush.
REQ-025: flush=1 SHALL force IDLE at the next edge with no done pulse.
REQ-026: flush SHALL take priority over start in the same cycle.
REQ-027: The counter cnt SHALL be clog2(W)+1 bits wide, with no wrap (maximum value W).
REQ-028: r SHALL be zero-extended to W.
REQ-029: The CLO result SHALL equal the CLZ result of ~a, including a=all-ones giving r=W.

Reset
REQ-030: On rst_n=0, asynchronously: state=IDLE, busy=0, done=0, r=0, sh=0, cnt=0, idx=0.
REQ-031: Reset asserted mid-SCAN SHALL abandon the operation with no done pulse.
REQ-032: The first start after reset release SHALL be accepted normally.

Structure
REQ-033: The shared package SHALL hold the state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2), the op encoding (OP_CLZ=0, OP_CLO=1), and defaults W=32 and CH=8.
REQ-034: One sub-module, clz_chunk, SHALL be instantiated: a combinational CH-bit leading-zero count returning 0..CH.
REQ-035: There SHALL be no other sub-modules; all sequencing SHALL reside in clz_seq.

Verification
REQ-036: Stimulus start, op=0, a=0x80000000 -> done in cycle T+2, r=0.
REQ-037: Stimulus start, op=0, a=0x00000001 -> done in cycle T+5, r=31; a=0x00000000 -> done in T+5, r=32.
REQ-038: Stimulus start, op=1, a=0xFFFF0F00 -> r=16, done in T+4; a=0xFFFFFFFF with op=1 -> r=32.
REQ-039: Stimulus start during busy, then start in the DONE cycle with a=0x00F00000 -> the first start is ignored, the second is accepted back-to-back, r=8, with done in cycle D+3, where D is the cycle in which the preceding done was high.
REQ-040: Stimulus flush in the second SCAN cycle, and separately rst_n low mid-SCAN -> no done pulse, busy=0 next cycle, r unchanged (reset case: r=0).
